shift_subtract_divider: RTL and testbench
=========================================

Name: shift_subtract_divider

Overview:
- Sequential restoring divider; the shift-subtract counterpart of the team's bit-slice add/sub/shift ALU datapath.
- Performs one quotient-bit iteration per clock using a WIDTH+1-bit trial subtract.
- Sits beside the ALU in the execute stage and serves divide instructions through a start/busy/done handshake.

Parameters:
WIDTH, 64, operand/result width in bits (bench also runs WIDTH=8)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  result, held until next accepted start
remainder  output  WIDTH  result, held until next accepted start
divByZero  output  1  set with done when divisor==0, held like results

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, iteration counter 0.
  - Internal registers 0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 and divisor!=0 -> RUN. Load rem=0, quo=dividend, div=divisor, count=WIDTH, clear divByZero.
  - IDLE: start=1 and divisor==0 -> DONE. quotient=all ones, remainder=dividend, divByZero=1.
  - RUN, each edge:
    - Shift {rem,quo} left 1.
    - trial = {1'b0,rem_shifted} - {1'b0,div} (WIDTH+1 bits).
    - If trial MSB==0: rem=trial[WIDTH-1:0] and quo[0]=1; else rem is unchanged and quo[0]=0.
    - count decrements; on the edge where count goes 1->0, state -> DONE.
  - DONE: lasts exactly one cycle, then -> IDLE.
- done: registered, equals (state==DONE).
- busy: registered, equals (state==RUN).
- Latency:
  - Start sampled at edge k -> done high in the cycle after edge k+WIDTH.
  - Divide-by-zero: done high in the cycle after edge k.
- quotient/remainder update only on the edge that enters DONE. Intermediate values are never visible on the outputs.
- start is ignored in RUN and DONE (no queuing). Operand changes after the accepted start have no effect.
- Back-to-back: start may be asserted in the cycle done is high. It is not accepted until the following cycle (IDLE).
- Reset mid-RUN: next edge returns to IDLE with all outputs 0. No done pulse is generated for the aborted operation.
- Arithmetic is unsigned: dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined:
  - Adds input signedOp (1 bit), captured on accepted start.
  - If signedOp=1: operands are converted to magnitudes on the load edge.
  - The core runs unsigned, followed by one FIXUP state between RUN and DONE. FIXUP negates the quotient if the operand signs differ and gives the remainder the sign of the dividend.
  - Signed latency is WIDTH+1 edges.
  - Overflow case MIN/-1 gives quotient=MIN, remainder=0, no flag.
  - Signed divide-by-zero gives quotient=all ones, remainder=dividend.
  - signedOp=0 behaves exactly as the unsigned build (no FIXUP cycle).
- Undefined:
  - No signedOp port and no FIXUP state.
  - Unsigned only.

Test Plan (WIDTH=8):
1. dividend=100, divisor=7, start pulse -> busy high 8 cycles, done after edge k+8, quotient=14, remainder=2, divByZero=0.
2. 255/1 and 3/10 back-to-back, with start asserted during the done cycle -> second op accepted one cycle later. Results 255/0, then 0/3.
3. 5/0 -> done after edge k, quotient=0xFF, remainder=5, divByZero=1, busy never high. A following 9/3 clears divByZero and gives 3/0.
4. Start 200/9, pulse start again at cycle 3 with 50/5, then reset at cycle 5 -> second start ignored. After reset: IDLE, all outputs 0, no done pulse. New 200/9 gives 22/2.
5. Random sweep of 1000 unsigned pairs plus corner pairs (0/x, x/x, 0xFF/0x80) -> quotient*divisor+remainder == dividend and remainder < divisor on every done.
6. SIGNED_DIV_EN, signedOp=1:
   - -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2), done after edge k+9.
   - -128/-1 -> quotient=0x80, remainder=0.
   - 100/-7 -> quotient=0xF2, remainder=2.

Source files
------------

// File: rtl/shift_subtract_divider.sv
// shift_subtract_divider: sequential restoring divider, one quotient bit per clock.
// A start/busy/done handshake; results and divByZero are held until the next accepted start.
// Optional signed support (signedOp input plus a FIXUP cycle) is enabled by the macro SIGNED_DIV_EN.
module shift_subtract_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             signedOp,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH:0]   trial;
    logic             last_iter;
    logic [WIDTH-1:0] load_dividend;
    logic [WIDTH-1:0] load_divisor;
`ifdef SIGNED_DIV_EN
    logic             signed_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
`endif

    assign last_iter = (count_q == CW'(1));

    // Operand values loaded into the core: magnitudes for signed requests, raw otherwise
    always_comb begin
        load_dividend = dividend;
        load_divisor  = divisor;
`ifdef SIGNED_DIV_EN
        if (signedOp && dividend[WIDTH-1]) load_dividend = -dividend;
        if (signedOp && divisor[WIDTH-1])  load_divisor  = -divisor;
`endif
    end

    // One restoring iteration: shift {rem,quo} left, trial-subtract the divisor, keep it if no borrow
    always_comb begin
        rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_shift = {quo_q[WIDTH-2:0], 1'b0};
        trial     = {1'b0, rem_shift} - {1'b0, div_q};
        rem_next  = rem_shift;
        quo_next  = quo_shift;
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo_shift[WIDTH-1:1], 1'b1};
        end
    end

    // Next-state logic for the handshake FSM
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_iter) begin
`ifdef SIGNED_DIV_EN
                    state_next = signed_q ? FIXUP : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIXUP:   state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Datapath: operand load, iteration, and result registers written only when entering DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            count_q   <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
`ifdef SIGNED_DIV_EN
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            divByZero <= 1'b1;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= load_dividend;
                            div_q     <= load_divisor;
                            count_q   <= CW'(WIDTH);
                            divByZero <= 1'b0;
`ifdef SIGNED_DIV_EN
                            signed_q  <= signedOp;
                            neg_quo_q <= signedOp & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_rem_q <= signedOp & dividend[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    count_q <= count_q - CW'(1);
                    if (last_iter && (state_next == DONE)) begin
                        quotient  <= quo_next;
                        remainder <= rem_next;
                    end
                end
`ifdef SIGNED_DIV_EN
                FIXUP: begin
                    quotient  <= neg_quo_q ? -quo_q : quo_q;
                    remainder <= neg_rem_q ? -rem_q : rem_q;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_subtract_divider.sv
// tb_shift_subtract_divider: table-driven directed vectors, hand-written corner sequences
// and a randomized sweep checked against an arithmetic reference model (WIDTH=8).
// Signed vectors are included when SIGNED_DIV_EN is defined.
module tb_shift_subtract_divider;
    localparam int W = 8;
`ifdef SIGNED_DIV_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_in = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divByZero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs[$];

    shift_subtract_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef SIGNED_DIV_EN
        .signedOp  (signed_in),
`endif
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected results from plain arithmetic on the operand values
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                     output logic [W-1:0] q, output logic [W-1:0] r,
                                     output logic dbz, output int lat);
        int sa;
        int sb;
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1; lat = 0;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q = W'(sa / sb);
            r = W'(sa % sb);
            dbz = 1'b0;
            lat = W + 1;
        end else begin
            q = a / b; r = a % b; dbz = 1'b0; lat = W;
        end
    endfunction

    // Present one request; returns just after the accepting edge with junk on the operand inputs
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        dividend  = a;
        divisor   = b;
        signed_in = SIGNED_BUILD & sgn;
        start     = 1'b1;
        step();
        start     = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        signed_in = SIGNED_BUILD & 1'($urandom);
    endtask

    // Full operation: returns in the done cycle after checking latency, busy count and results
    task automatic doDivide(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                            input int elat, input string name);
        int lat;
        int busy_cycles;
        applyStimulus(a, b, sgn);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat <= elat + 4) begin
            if (busy) busy_cycles++;
            step();
            lat++;
        end
        checkOutput({name, " done"}, 64'(done), 64'd1);
        checkOutput({name, " latency"}, 64'(lat), 64'(elat));
        checkOutput({name, " busy cycles"}, 64'(busy_cycles), (b == '0) ? 64'd0 : 64'(W));
        checkOutput({name, " busy in done"}, 64'(busy), 64'd0);
        checkOutput({name, " quotient"}, 64'(quotient), 64'(eq));
        checkOutput({name, " remainder"}, 64'(remainder), 64'(er));
        checkOutput({name, " divByZero"}, 64'(divByZero), 64'(edbz));
    endtask

    // Leave the done cycle: done must drop and results must hold
    task automatic finishOp(input logic [W-1:0] eq, input logic [W-1:0] er, input string name);
        step();
        checkOutput({name, " done pulse width"}, 64'(done), 64'd0);
        checkOutput({name, " quotient held"}, 64'(quotient), 64'(eq));
        checkOutput({name, " remainder held"}, 64'(remainder), 64'(er));
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
        int           elat;
        int           done_seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        // Directed vector table
        vecs.push_back('{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0, W, "u 100/7"});
        vecs.push_back('{8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,   1'b1, 0, "u 5/0"});
        vecs.push_back('{8'd9,   8'd3,   1'b0, 8'd3,   8'd0,   1'b0, W, "u 9/3 after dbz"});
        vecs.push_back('{8'd0,   8'd7,   1'b0, 8'd0,   8'd0,   1'b0, W, "u 0/7"});
        vecs.push_back('{8'd37,  8'd37,  1'b0, 8'd1,   8'd0,   1'b0, W, "u 37/37"});
        vecs.push_back('{8'hFF,  8'h80,  1'b0, 8'd1,   8'h7F,  1'b0, W, "u FF/80"});
        vecs.push_back('{8'hFF,  8'hFF,  1'b0, 8'd1,   8'd0,   1'b0, W, "u FF/FF"});
        vecs.push_back('{8'd1,   8'hFF,  1'b0, 8'd0,   8'd1,   1'b0, W, "u 1/FF"});
        vecs.push_back('{8'd0,   8'd0,   1'b0, 8'hFF,  8'd0,   1'b1, 0, "u 0/0"});
        if (SIGNED_BUILD) begin
            vecs.push_back('{8'h9C, 8'd7,   1'b1, 8'hF2, 8'hFE, 1'b0, W + 1, "s -100/7"});
            vecs.push_back('{8'h80, 8'hFF,  1'b1, 8'h80, 8'd0,  1'b0, W + 1, "s MIN/-1"});
            vecs.push_back('{8'd100, 8'hF9, 1'b1, 8'hF2, 8'd2,  1'b0, W + 1, "s 100/-7"});
            vecs.push_back('{8'h9C, 8'hF9,  1'b1, 8'd14, 8'hFE, 1'b0, W + 1, "s -100/-7"});
            vecs.push_back('{8'h9C, 8'd0,   1'b1, 8'hFF, 8'h9C, 1'b1, 0,     "s -100/0"});
            vecs.push_back('{8'h9C, 8'd7,   1'b0, 8'd22, 8'd2,  1'b0, W,     "u 156/7 signedOp=0"});
        end

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset quotient", 64'(quotient), 64'd0);
        checkOutput("reset remainder", 64'(remainder), 64'd0);
        checkOutput("reset divByZero", 64'(divByZero), 64'd0);
        step();

        // Table-driven directed vectors
        foreach (vecs[i]) begin
            doDivide(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r,
                     vecs[i].dbz, vecs[i].lat, vecs[i].name);
            finishOp(vecs[i].q, vecs[i].r, vecs[i].name);
        end

        // Back-to-back: start raised during done is only accepted once back in IDLE
        doDivide(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, W, "b2b 255/1");
        dividend = 8'd3;
        divisor  = 8'd10;
        start    = 1'b1;
        step();
        checkOutput("b2b start ignored in done", 64'(busy), 64'd0);
        checkOutput("b2b done dropped", 64'(done), 64'd0);
        checkOutput("b2b first quotient held", 64'(quotient), 64'd255);
        doDivide(8'd3, 8'd10, 1'b0, 8'd0, 8'd3, 1'b0, W, "b2b 3/10");
        finishOp(8'd0, 8'd3, "b2b 3/10");

        // Start ignored while running, then reset aborts without a done pulse
        applyStimulus(8'd200, 8'd9, 1'b0);
        step();
        step();
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        step();
        start    = 1'b0;
        checkOutput("abort still busy after ignored start", 64'(busy), 64'd1);
        checkOutput("abort no early done", 64'(done), 64'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort busy cleared", 64'(busy), 64'd0);
        checkOutput("abort done cleared", 64'(done), 64'd0);
        checkOutput("abort quotient cleared", 64'(quotient), 64'd0);
        checkOutput("abort remainder cleared", 64'(remainder), 64'd0);
        checkOutput("abort divByZero cleared", 64'(divByZero), 64'd0);
        done_seen = 0;
        for (int c = 0; c < W + 4; c++) begin
            if (done || busy) done_seen++;
            step();
        end
        checkOutput("abort no activity after reset", 64'(done_seen), 64'd0);
        doDivide(8'd200, 8'd9, 1'b0, 8'd22, 8'd2, 1'b0, W, "after abort 200/9");
        finishOp(8'd22, 8'd2, "after abort 200/9");

        // Randomized sweep against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 31) == 0) ? W'(0) : W'($urandom);
            rs = SIGNED_BUILD & 1'($urandom);
            refModel(ra, rb, rs, eq, er, edbz, elat);
            doDivide(ra, rb, rs, eq, er, edbz, elat, "random");
            if (!rs && rb != '0) begin
                checkOutput("random q*d+r==n", 64'(int'(quotient) * int'(rb) + int'(remainder)), 64'(ra));
                checkOutput("random r<d", 64'(remainder < rb), 64'd1);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
